// File: rtl/gpio_in_cond20.sv
// gpio_in_cond20: GPIO input conditioning. Synchronises the pads, optionally
// debounces each bit, detects rising/falling edges on pins configured as inputs
// and keeps sticky per-bit interrupt status plus a combined interrupt line.
// Optional feature macro: GPIO_IN_DEBOUNCE_EN (per-bit debounce counters).
`timescale 1ns/1ps

module gpio_in_cond20 #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DB_CNT_W = 4
) (
  input  logic                pclk20,
  input  logic                p_reset20,
  input  logic [WIDTH-1:0]    gpio_pin_in20,
  input  logic [WIDTH-1:0]    n_gpio_pin_oe20,
  input  logic [WIDTH-1:0]    cfg_rise_en,
  input  logic [WIDTH-1:0]    cfg_fall_en,
  input  logic [DB_CNT_W-1:0] cfg_db_thresh,
  input  logic [WIDTH-1:0]    irq_clr,
  output logic [WIDTH-1:0]    gpio_in_sync,
  output logic [WIDTH-1:0]    irq_status,
  output logic                irq
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [1:0]       prime_cnt;
  logic             primed;

  // Two-flop synchroniser for the asynchronous pad inputs
  always_ff @(posedge pclk20 or posedge p_reset20) begin
    if (p_reset20) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= gpio_pin_in20;
      s2 <= s1;
    end
  end

  // Priming counter: saturates at 3 so that levels present at reset release
  // are absorbed instead of being reported as edges
  always_ff @(posedge pclk20 or posedge p_reset20) begin
    if (p_reset20) begin
      prime_cnt <= 2'd0;
    end else if (prime_cnt != 2'd3) begin
      prime_cnt <= prime_cnt + 2'd1;
    end
  end

  assign primed = (prime_cnt == 2'd3);

`ifdef GPIO_IN_DEBOUNCE_EN
  logic [WIDTH-1:0]    filt_q;
  logic [DB_CNT_W-1:0] db_cnt [WIDTH];

  // Per-bit debounce: filt follows s2 only after more than cfg_db_thresh
  // consecutive mismatching cycles; >= copes with a threshold lowered mid-count
  always_ff @(posedge pclk20 or posedge p_reset20) begin
    if (p_reset20) begin
      filt_q <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        db_cnt[i] <= '0;
      end
    end else if (!primed) begin
      filt_q <= s2;
      for (int i = 0; i < int'(WIDTH); i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (s2[i] == filt_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] >= cfg_db_thresh) begin
          filt_q[i] <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_CNT_W'(1);
        end
      end
    end
  end

  // While priming, expose s2 directly so prev tracks the settled pin level
  assign filt = primed ? filt_q : s2;
`else
  logic unused_db_thresh;

  assign filt             = s2;
  assign unused_db_thresh = ^cfg_db_thresh;
`endif

  assign gpio_in_sync = filt;

  // Previous conditioned value for edge detection
  always_ff @(posedge pclk20 or posedge p_reset20) begin
    if (p_reset20) begin
      prev <= '0;
    end else begin
      prev <= filt;
    end
  end

  // Edge qualification uses live enables so configuration changes act at once
  always_comb begin
    rise = '0;
    fall = '0;
    if (primed) begin
      rise = filt  & ~prev & cfg_rise_en & n_gpio_pin_oe20;
      fall = ~filt &  prev & cfg_fall_en & n_gpio_pin_oe20;
    end
  end

  // Sticky status with write-1-to-clear; a coincident set wins over clear
  always_ff @(posedge pclk20 or posedge p_reset20) begin
    if (p_reset20) begin
      irq_status <= '0;
    end else begin
      irq_status <= (irq_status & ~irq_clr) | rise | fall;
    end
  end

  assign irq = |irq_status;

endmodule

// File: tb/tb_gpio_in_cond20.sv
// Self-checking bench for gpio_in_cond20 with a behavioural reference model.
// Honours GPIO_IN_DEBOUNCE_EN to match the build of the design.
`timescale 1ns/1ps

module tb_gpio_in_cond20;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 4;
`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int DB = 1;
`else
  localparam int DB = 0;
`endif

  logic          clk;
  logic          rst;
  logic [W-1:0]  pin;
  logic [W-1:0]  oe;
  logic [W-1:0]  ren;
  logic [W-1:0]  fen;
  logic [CW-1:0] thr;
  logic [W-1:0]  clr;
  logic [W-1:0]  sync_o;
  logic [W-1:0]  status_o;
  logic          irq_o;

  int checks = 0;
  int errors = 0;

  gpio_in_cond20 #(.WIDTH(W), .DB_CNT_W(CW)) dut (
    .pclk20          (clk),
    .p_reset20       (rst),
    .gpio_pin_in20   (pin),
    .n_gpio_pin_oe20 (oe),
    .cfg_rise_en     (ren),
    .cfg_fall_en     (fen),
    .cfg_db_thresh   (thr),
    .irq_clr         (clr),
    .gpio_in_sync    (sync_o),
    .irq_status      (status_o),
    .irq             (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pin seen two edges late; the debounced level flips after
  // more than thr consecutive disagreeing cycles; edges of the visible level
  // are reported only once three cycles have passed since reset.
  logic [W-1:0] m_s1, m_s2, m_filt, m_prev, m_status;
  int           m_run [W];
  int           m_n;

  function automatic logic [W-1:0] m_visible();
    if (DB != 0 && m_n >= 3) return m_filt;
    return m_s2;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [W-1:0] vis, r, f;
    logic         pr;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_filt = '0; m_prev = '0; m_status = '0; m_n = 0;
      for (int b = 0; b < int'(W); b++) m_run[b] = 0;
    end else begin
      pr  = (m_n >= 3);
      vis = m_visible();
      r   = pr ? (vis & ~m_prev & ren & oe) : '0;
      f   = pr ? (~vis & m_prev & fen & oe) : '0;
      m_status = (m_status & ~clr) | r | f;
      m_prev   = vis;
      if (!pr) begin
        m_filt = m_s2;
        for (int b = 0; b < int'(W); b++) m_run[b] = 0;
      end else begin
        for (int b = 0; b < int'(W); b++) begin
          if (m_s2[b] == m_filt[b]) m_run[b] = 0;
          else if (m_run[b] >= int'(thr)) begin
            m_filt[b] = m_s2[b];
            m_run[b]  = 0;
          end else m_run[b]++;
        end
      end
      m_s2 = m_s1;
      m_s1 = pin;
      if (m_n < 3) m_n++;
    end
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    check("sync_model",   32'(sync_o),   32'(m_visible()));
    check("status_model", 32'(status_o), 32'(m_status));
    check("irq_model",    32'(irq_o),    32'(|m_status));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pin = '1; oe = '1; ren = '1; fen = '0; thr = '0; clr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Pins already high at reset release must not create edges
    step(3);
    check("rst_rel_sync",   32'(sync_o),   32'h0000_FFFF);
    check("rst_rel_status", 32'(status_o), 32'h0);
    step(4);
    check("rst_rel_status2", 32'(status_o), 32'h0);
    check("rst_rel_irq",     32'(irq_o),    32'h0);

    // Bit 3 rising edge with threshold 0, then clear
    pin = 16'hFFF7;
    step(8);
    pin = 16'hFFFF;
    step(2 + DB);
    check("b3_before", 32'(status_o), 32'h0);
    step(1);
    check("b3_status", 32'(status_o), 32'h0008);
    check("b3_irq",    32'(irq_o),    32'h1);
    clr = 16'h0008;
    step(1);
    clr = '0;
    check("b3_clr_status", 32'(status_o), 32'h0);
    check("b3_clr_irq",    32'(irq_o),    32'h0);

    // Bit 5 as output: follows the pin but never flags an edge
    fen = '1;
    oe  = 16'hFFDF;
    for (int i = 0; i < 4; i++) begin
      pin[5] = ~pin[5];
      step(5);
      check("b5_sync",   32'(sync_o[5]),   32'(pin[5]));
      check("b5_status", 32'(status_o[5]), 32'h0);
    end
    oe = '1;
    step(3);
    check("b5_after_oe", 32'(status_o), 32'h0);

    // Bit 2 falling edge in the same cycle as its clear: set wins
    pin[2] = 1'b0;
    step(2 + DB);
    clr = 16'h0004;
    step(1);
    clr = '0;
    check("b2_set_wins", 32'(status_o[2]), 32'h1);
    clr = 16'h0004;
    step(1);
    clr = '0;
    check("b2_cleared", 32'(status_o), 32'h0);

`ifdef GPIO_IN_DEBOUNCE_EN
    // Debounce with T=4: a 3-cycle glitch is rejected, a 6-cycle pulse passes
    thr = 4'd4;
    pin[0] = 1'b0;
    step(12);
    clr = '1;
    step(1);
    clr = '0;
    check("db_prep", 32'(status_o), 32'h0);
    pin[0] = 1'b1;
    step(3);
    pin[0] = 1'b0;
    step(12);
    check("db_glitch_sync",   32'(sync_o[0]), 32'h0);
    check("db_glitch_status", 32'(status_o),  32'h0);
    pin[0] = 1'b1;
    step(6);
    pin[0] = 1'b0;
    step(1);
    check("db_e7_sync",   32'(sync_o[0]),   32'h1);
    check("db_e7_status", 32'(status_o[0]), 32'h0);
    step(1);
    check("db_e8_status", 32'(status_o[0]), 32'h1);
    step(12);
    clr = '1;
    step(1);
    clr = '0;
`endif

    // Reset mid-operation while bit 1 is part-way through its debounce count
    pin[1] = 1'b0;
    step(5);
    rst = 1'b1;
    #1;
    check("rst_mid_sync",   32'(sync_o),   32'h0);
    check("rst_mid_status", 32'(status_o), 32'h0);
    check("rst_mid_irq",    32'(irq_o),    32'h0);
    step(2);
    rst = 1'b0;
    step(8 + DB * 4);
    check("rst_post_status", 32'(status_o), 32'h0);
    check("rst_post_sync",   32'(sync_o),   32'(pin));

    // Randomised traffic against the model
    thr = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < int'(W); b++) begin
        if ($urandom_range(0, 15) == 0) pin[b] = ~pin[b];
      end
      if ($urandom_range(0, 63) == 0) oe  = W'($urandom);
      if ($urandom_range(0, 63) == 0) ren = W'($urandom);
      if ($urandom_range(0, 63) == 0) fen = W'($urandom);
      clr = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
      if (DB != 0 && $urandom_range(0, 99) == 0) thr = CW'($urandom_range(0, 5));
      if (c == 1500) rst = 1'b1;
      if (c == 1503) rst = 1'b0;
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
